// File: rtl/frame_sequencer.sv
// frame_sequencer: walks NUM_CH packed operand frames in lock-step depth order,
// issuing one read per channel per depth step, with bounded in-flight reads,
// programmable frame replay and a per-depth-step engine strobe.
// Optional feature: define FRAME_SEQ_BOUNDS_EN to enable the cfg_limit address
// bound check (fault reporting); otherwise cfg_limit is ignored and fault is 0.
//
// Handshake: a request transfers on a rising clk edge where req_valid and
// req_ready are both high; once raised, req_valid/req_addr/req_ch/req_last hold
// until that transfer, except that abort (or a bounds fault) withdraws it.
// rsp_valid is a one-cycle, always-accepted, in-order response notification.
module frame_sequencer #(
   parameter int ADDR_WIDTH      = 32,
   parameter int LANE_COUNT      = 15,
   parameter int NUM_CH          = 2,
   parameter int DEPTH_WIDTH     = 16,
   parameter int MAX_OUTSTANDING = 4,
   localparam int CH_W           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [NUM_CH*ADDR_WIDTH-1:0] cfg_base,
   input  logic [NUM_CH*8-1:0]          cfg_stride,
   input  logic [DEPTH_WIDTH-1:0]       cfg_depth,
   input  logic [7:0]                   cfg_repeat,
   input  logic [ADDR_WIDTH-1:0]        cfg_limit,
   input  logic                         start,
   input  logic                         abort,
   output logic                         busy,
   output logic                         done,
   output logic                         aborted,
   output logic                         fault,
   output logic                         req_valid,
   input  logic                         req_ready,
   output logic [ADDR_WIDTH-1:0]        req_addr,
   output logic [CH_W-1:0]              req_ch,
   output logic                         req_last,
   input  logic                         rsp_valid,
   output logic                         step,
   output logic [1:0]                   dbg_state
);

   localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
   localparam int BYTES = LANE_COUNT / 5;

   typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DRAIN = 2'd2} state_t;

   state_t                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   base_q   [NUM_CH];
   logic [ADDR_WIDTH-1:0]   addr_q   [NUM_CH];
   logic [7:0]              stride_q [NUM_CH];
   logic [DEPTH_WIDTH-1:0]  depth_cfg_q, depth_q;
   logic [7:0]              repeat_q, pass_q;
   logic [CH_W-1:0]         ch_q, rsp_ch_q;
   logic [CNT_W-1:0]        out_cnt_q;
   logic [ADDR_WIDTH-1:0]   inc;
   logic                    last_ch, last_depth, last_pass, at_max;
   logic                    accept, rsp_take, viol;

   // Position flags and the request bus, all derived from registered state.
   always_comb begin
      last_ch    = (ch_q == CH_W'(NUM_CH - 1));
      last_depth = (depth_q == depth_cfg_q - DEPTH_WIDTH'(1));
      last_pass  = (pass_q == repeat_q);
      at_max     = (out_cnt_q == CNT_W'(MAX_OUTSTANDING));
      inc        = ADDR_WIDTH'(BYTES) * ADDR_WIDTH'(stride_q[ch_q]);
      req_addr   = addr_q[ch_q];
      req_ch     = ch_q;
      req_valid  = (state_q == ISSUE) && !abort && !viol && !at_max;
      req_last   = req_valid && last_ch && last_depth && last_pass;
      accept     = req_valid && req_ready;
      rsp_take   = rsp_valid && (out_cnt_q != '0);
      busy       = (state_q != IDLE);
      dbg_state  = state_q;
   end

`ifdef FRAME_SEQ_BOUNDS_EN
   logic [ADDR_WIDTH-1:0] limit_q;
   logic                  fault_q;

   // A read whose last byte would land past the limit is never presented.
   assign viol  = (state_q == ISSUE) &&
                  (({1'b0, req_addr} + (ADDR_WIDTH + 1)'(BYTES)) > {1'b0, limit_q});
   assign fault = fault_q;

   // Limit capture and sticky fault flag, cleared by the next accepted start.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         limit_q <= '0;
         fault_q <= 1'b0;
      end else if (state_q == IDLE && start) begin
         limit_q <= cfg_limit;
         fault_q <= 1'b0;
      end else if (state_q == ISSUE && !abort && viol) begin
         fault_q <= 1'b1;
      end
   end
`else
   logic unused_limit;
   assign unused_limit = ^cfg_limit;
   assign viol         = 1'b0;
   assign fault        = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next-state: issue until the final request, abort or fault, then drain.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start && cfg_depth != '0) state_d = ISSUE;
         ISSUE:   if (abort || viol || (accept && req_last)) state_d = DRAIN;
         DRAIN:   if (out_cnt_q == '0) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Sequence position, addresses, credit counter, step strobe and status.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int c = 0; c < NUM_CH; c++) begin
            base_q[c]   <= '0;
            addr_q[c]   <= '0;
            stride_q[c] <= '0;
         end
         depth_cfg_q <= '0;
         depth_q     <= '0;
         repeat_q    <= '0;
         pass_q      <= '0;
         ch_q        <= '0;
         rsp_ch_q    <= '0;
         out_cnt_q   <= '0;
         step        <= 1'b0;
         done        <= 1'b0;
         aborted     <= 1'b0;
      end else begin
         step <= 1'b0;
         if (accept && !rsp_take)      out_cnt_q <= out_cnt_q + CNT_W'(1);
         else if (!accept && rsp_take) out_cnt_q <= out_cnt_q - CNT_W'(1);
         if (rsp_take) begin
            step     <= (rsp_ch_q == CH_W'(NUM_CH - 1));
            rsp_ch_q <= (rsp_ch_q == CH_W'(NUM_CH - 1)) ? '0 : rsp_ch_q + CH_W'(1);
         end
         case (state_q)
            IDLE: begin
               if (start) begin
                  for (int c = 0; c < NUM_CH; c++) begin
                     base_q[c]   <= cfg_base[c*ADDR_WIDTH +: ADDR_WIDTH];
                     addr_q[c]   <= cfg_base[c*ADDR_WIDTH +: ADDR_WIDTH];
                     stride_q[c] <= cfg_stride[c*8 +: 8];
                  end
                  depth_cfg_q <= cfg_depth;
                  repeat_q    <= cfg_repeat;
                  depth_q     <= '0;
                  pass_q      <= '0;
                  ch_q        <= '0;
                  rsp_ch_q    <= '0;
                  done        <= (cfg_depth == '0);
                  aborted     <= 1'b0;
               end
            end
            ISSUE: begin
               if (abort) aborted <= 1'b1;
               if (accept) begin
                  addr_q[ch_q] <= addr_q[ch_q] + inc;
                  if (last_ch) begin
                     ch_q <= '0;
                     if (last_depth) begin
                        // End of a pass: replay from the latched bases.
                        depth_q <= '0;
                        pass_q  <= pass_q + 8'd1;
                        for (int c = 0; c < NUM_CH; c++) addr_q[c] <= base_q[c];
                     end else begin
                        depth_q <= depth_q + DEPTH_WIDTH'(1);
                     end
                  end else begin
                     ch_q <= ch_q + CH_W'(1);
                  end
               end
            end
            DRAIN: if (out_cnt_q == '0) done <= 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_frame_sequencer.sv
// tb_frame_sequencer: directed and randomized sequences for frame_sequencer.
// Expected requests come from a closed-form frame walk (base + depth*bytes*stride
// over pass/depth/channel loops) pushed into exp_q at start; a negedge monitor
// drives ready/responses, pops and compares every accepted request.
module tb_frame_sequencer;

   localparam int AW    = 32;
   localparam int LC    = 15;
   localparam int NCH   = 2;
   localparam int DW    = 16;
   localparam int MAXO  = 4;
   localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int BYTES = LC / 5;
   localparam int EW    = AW + CH_W + 1;
`ifdef FRAME_SEQ_BOUNDS_EN
   localparam bit BOUNDS = 1'b1;
`else
   localparam bit BOUNDS = 1'b0;
`endif

   logic              clk, reset;
   logic [NCH*AW-1:0] cfg_base;
   logic [NCH*8-1:0]  cfg_stride;
   logic [DW-1:0]     cfg_depth;
   logic [7:0]        cfg_repeat;
   logic [AW-1:0]     cfg_limit;
   logic              start, abort;
   logic              busy, done, aborted, fault;
   logic              req_valid, req_ready, req_last, rsp_valid, step;
   logic [AW-1:0]     req_addr;
   logic [CH_W-1:0]   req_ch;
   logic [1:0]        dbg_state;

   frame_sequencer #(.ADDR_WIDTH(AW), .LANE_COUNT(LC), .NUM_CH(NCH),
                     .DEPTH_WIDTH(DW), .MAX_OUTSTANDING(MAXO)) dut (
      .clk(clk), .reset(reset), .cfg_base(cfg_base), .cfg_stride(cfg_stride),
      .cfg_depth(cfg_depth), .cfg_repeat(cfg_repeat), .cfg_limit(cfg_limit),
      .start(start), .abort(abort), .busy(busy), .done(done), .aborted(aborted),
      .fault(fault), .req_valid(req_valid), .req_ready(req_ready),
      .req_addr(req_addr), .req_ch(req_ch), .req_last(req_last),
      .rsp_valid(rsp_valid), .step(step), .dbg_state(dbg_state));

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- scoreboard state ----------------
   logic [EW-1:0] exp_q[$];
   int n_checks = 0, n_pass = 0;
   int pend = 0, acc_total = 0, step_cnt = 0;
   int rsp_mode = 0;           // 0 immediate, 1 none, 2 random
   bit rdy_on = 1'b1, rdy_rand = 1'b0, rsp_force = 1'b0;
   logic [AW-1:0] base_a [NCH];
   logic [7:0]    stride_a [NCH];
   int            depth_v, rep_v;
   logic [AW-1:0] limit_v;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      n_checks++;
      if (got === want) n_pass++;
      else $display("FAIL %s: got 0x%0h required 0x%0h", name, got, want);
   endtask

   // Reference frame walk: closed-form addresses, stop at first bound violation.
   task automatic build_model(output int n, output bit flt);
      logic [AW-1:0] a;
      logic          lst;
      n = 0; flt = 1'b0;
      for (int p = 0; p <= rep_v; p++)
         for (int d = 0; d < depth_v; d++)
            for (int c = 0; c < NCH; c++) begin
               a   = base_a[c] + AW'(d * BYTES * int'(stride_a[c]));
               lst = (p == rep_v) && (d == depth_v - 1) && (c == NCH - 1);
               if (BOUNDS && (({1'b0, a} + 33'(BYTES)) > {1'b0, limit_v})) begin
                  flt = 1'b1;
                  return;
               end
               exp_q.push_back({lst, CH_W'(c), a});
               n++;
            end
   endtask

   // ---------------- monitor: drives ready/responses, checks requests ----------------
   initial begin
      logic [EW-1:0] e;
      bit acc;
      rsp_valid = 1'b0;
      req_ready = 1'b0;
      forever begin
         @(negedge clk);
         if (reset) begin
            pend = 0; rsp_valid = 1'b0;
            continue;
         end
         req_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_on;
         if (rsp_force) begin
            rsp_valid = 1'b1; rsp_force = 1'b0;
         end else if (rsp_mode == 0) rsp_valid = (pend > 0);
         else if (rsp_mode == 2)     rsp_valid = (pend > 0) && ($urandom_range(0, 1) == 1);
         else                        rsp_valid = 1'b0;
         if (step) step_cnt++;
         acc = req_valid && req_ready;
         if (acc) begin
            acc_total++;
            if (exp_q.size() == 0) check("unexpected_req", {req_last, req_ch, req_addr}, '0);
            else begin
               e = exp_q.pop_front();
               check("req_last_ch_addr", {req_last, req_ch, req_addr}, e);
            end
         end
         pend = pend + (acc ? 1 : 0) - ((rsp_valid && pend > 0) ? 1 : 0);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic set_cfg();
      for (int c = 0; c < NCH; c++) begin
         cfg_base[c*AW +: AW] = base_a[c];
         cfg_stride[c*8 +: 8] = stride_a[c];
      end
      cfg_depth  = DW'(depth_v);
      cfg_repeat = 8'(rep_v);
      cfg_limit  = limit_v;
   endtask

   task automatic pulse_start();
      acc_total = 0; step_cnt = 0;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_cycles(input int n);
      for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
   endtask

   task automatic wait_done(input int budget);
      int i;
      i = 0;
      while (!done && i < budget) begin @(posedge clk); #1; i++; end
      check("done_seen", done, 1);
      wait_cycles(2);
   endtask

   task automatic end_checks(input string tag, input bit exp_ab, input bit exp_flt, input int exp_steps);
      check({tag, "_aborted"}, aborted, exp_ab);
      check({tag, "_fault"}, fault, exp_flt);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_steps"}, step_cnt, exp_steps);
   endtask

   // Full sequence run with model-generated expectations.
   task automatic run_seq(input string tag, input bit scramble);
      int n; bit flt;
      build_model(n, flt);
      set_cfg();
      pulse_start();
      if (scramble) begin
         cfg_base = {$urandom, $urandom}; cfg_stride = 16'($urandom);
         cfg_depth = DW'($urandom); cfg_repeat = 8'($urandom);
      end
      wait_done(3000);
      check({tag, "_queue_left"}, exp_q.size(), 0);
      end_checks(tag, 1'b0, flt, n / NCH);
   endtask

   task automatic set_std(input int depth, input int rep);
      base_a[0] = 32'h1000; base_a[1] = 32'h2000;
      stride_a[0] = 8'd1;   stride_a[1] = 8'd1;
      depth_v = depth; rep_v = rep; limit_v = 32'hFFFF_FFFF;
   endtask

   // ---------------- main stimulus ----------------
   initial begin
      int n; bit flt; int i;
      reset = 1'b1; start = 1'b0; abort = 1'b0;
      set_std(3, 0); set_cfg();
      wait_cycles(3);
      check("rst_busy", busy, 0);       check("rst_done", done, 0);
      check("rst_aborted", aborted, 0); check("rst_fault", fault, 0);
      check("rst_req_valid", req_valid, 0); check("rst_req_last", req_last, 0);
      check("rst_step", step, 0);       check("rst_req_addr", req_addr, 0);
      check("rst_req_ch", req_ch, 0);   check("rst_state", dbg_state, 0);
      reset = 1'b0;
      wait_cycles(2);

      // Zero depth: done the cycle after start, no requests.
      set_std(0, 0); set_cfg();
      pulse_start();
      check("d0_done", done, 1); check("d0_busy", busy, 0); check("d0_req_valid", req_valid, 0);
      wait_cycles(3);
      check("d0_steps", step_cnt, 0);

      // Basic two-channel walk; also checks start latency and done clear.
      set_std(3, 0);
      build_model(n, flt);
      set_cfg();
      pulse_start();
      check("t1_req_valid_n1", req_valid, 1);
      check("t1_done_cleared", done, 0);
      wait_done(200);
      check("t1_queue_left", exp_q.size(), 0);
      end_checks("t1", 1'b0, 1'b0, 3);

      // Credit limit: no responses -> exactly MAXO accepted, one response frees one.
      set_std(4, 0);
      build_model(n, flt);
      set_cfg();
      rsp_mode = 1;
      pulse_start();
      wait_cycles(12);
      check("fc_accepted_max", acc_total, MAXO);
      check("fc_valid_low", req_valid, 0);
      rsp_force = 1'b1;
      wait_cycles(6);
      check("fc_accepted_one_more", acc_total, MAXO + 1);
      check("fc_valid_low2", req_valid, 0);
      rsp_mode = 0;
      wait_done(200);
      check("fc_queue_left", exp_q.size(), 0);
      end_checks("fc", 1'b0, 1'b0, 4);

      // Replay: repeat 1, depth 2.
      set_std(2, 1);
      run_seq("rep", 1'b0);

      // Abort after third accept.
      set_std(3, 0);
      build_model(n, flt);
      set_cfg();
      pulse_start();
      i = 0;
      while (acc_total < 3 && i < 100) begin @(posedge clk); #1; i++; end
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      wait_done(200);
      check("ab_accepted", acc_total, 3);
      exp_q.delete();
      end_checks("ab", 1'b1, 1'b0, 1);

`ifdef FRAME_SEQ_BOUNDS_EN
      // Bound check: ch0 crosses 0x1009 at depth step 3.
      set_std(4, 0);
      base_a[1] = 32'h0800; limit_v = 32'h1009;
      run_seq("bnd", 1'b0);
      check("bnd_fault_on", fault, 1);
      check("bnd_accepted", acc_total, 6);
`endif

      // Response while nothing is outstanding must be ignored.
      rsp_force = 1'b1;
      wait_cycles(3);

      // Randomized sequences with random ready/response timing.
      rsp_mode = 2; rdy_rand = 1'b1;
      for (int t = 0; t < 8; t++) begin
         for (int c = 0; c < NCH; c++) begin
            base_a[c]   = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + AW'($urandom_range(0, 15))) : $urandom;
            stride_a[c] = 8'($urandom_range(0, 255));
         end
         depth_v = $urandom_range(1, 5); rep_v = $urandom_range(0, 2);
         limit_v = 32'hFFFF_FFFF;
         run_seq("rnd", 1'b1);
      end
      rsp_mode = 0; rdy_rand = 1'b0;

      // Reset in the middle of issuing.
      set_std(10, 0);
      build_model(n, flt);
      set_cfg();
      rsp_mode = 1;
      pulse_start();
      wait_cycles(2);
      reset = 1'b1;
      #1;
      check("mr_busy", busy, 0);           check("mr_req_valid", req_valid, 0);
      check("mr_req_addr", req_addr, 0);   check("mr_req_ch", req_ch, 0);
      check("mr_req_last", req_last, 0);   check("mr_step", step, 0);
      check("mr_done", done, 0);
      exp_q.delete();
      wait_cycles(2);
      reset = 1'b0;
      rsp_mode = 0;
      wait_cycles(2);

      // Recovery after reset.
      set_std(3, 0);
      run_seq("post", 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
